// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
//
// Global-history branch direction predictor for the fetch stage.
//
// A speculative global history register (GHR) is shifted at prediction time
// and indexes a table of saturating counters, either directly (MODE=0) or
// XORed with PC bits [GHR_WIDTH+1:2] (MODE=1, gshare). Execute writes
// outcomes back using the GHR snapshot that fetch carried down the pipeline.
// That snapshot is also used to repair the GHR on a mispredict. After reset a
// sweep clears every counter to weakly-not-taken before `ready` rises.
//
// Parameters
//   GHR_WIDTH    history length and table index width
//   TABLE_DEPTH  number of counters; must equal 2**GHR_WIDTH
//   CTR_WIDTH    saturating counter width (>= 2)
//   PC_WIDTH     program counter width
//   MODE         0: index = GHR, 1: index = GHR ^ pc[GHR_WIDTH+1:2]
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   pred_valid      fetch presents a branch for prediction
//   pred_pc         PC of the predicted branch
//   Stall_Detected  blocks the speculative GHR shift
//   pred_taken      predicted direction (combinational)
//   pred_ghr        current speculative GHR (snapshot for the pipeline)
//   ready           table initialised, predictions/updates accepted
//   upd_valid       execute resolves a branch
//   upd_pc          PC of the resolved branch
//   upd_ghr         GHR snapshot taken when the branch was predicted
//   upd_taken       actual outcome
//   upd_mispredict  prediction was wrong (qualified by upd_valid)
// -----------------------------------------------------------------------------
module gshare_predictor #(
    parameter int GHR_WIDTH   = 3,
    parameter int TABLE_DEPTH = 1 << GHR_WIDTH,
    parameter int CTR_WIDTH   = 2,
    parameter int PC_WIDTH    = 32,
    parameter int MODE        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid,
    input  logic [PC_WIDTH-1:0]  pred_pc,
    input  logic                 Stall_Detected,
    output logic                 pred_taken,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    output logic                 ready,
    input  logic                 upd_valid,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic [GHR_WIDTH-1:0] upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Weakly-not-taken: MSB clear, all lower bits set.
    localparam logic [CTR_WIDTH-1:0] CTR_WNT  = {1'b0, {(CTR_WIDTH-1){1'b1}}};
    localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
    localparam logic [GHR_WIDTH-1:0] LAST_IDX = GHR_WIDTH'(TABLE_DEPTH - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [GHR_WIDTH-1:0]   r_sweep_idx;
    logic [GHR_WIDTH-1:0]   r_ghr;
    logic [CTR_WIDTH-1:0]   r_ctr [TABLE_DEPTH];

    logic                   w_run;
    logic                   w_sweep_we;
    logic                   w_upd_we;
    logic [GHR_WIDTH-1:0]   w_pidx;
    logic [GHR_WIDTH-1:0]   w_uidx;
    logic                   w_ctr_msb;
    logic [CTR_WIDTH-1:0]   w_upd_cur;
    logic [CTR_WIDTH-1:0]   w_upd_nxt;
    logic                   w_unused;

    // In MODE=0 the PC inputs do not reach the index; fold them here so the
    // unused-bit lint stays quiet without touching the port list.
    assign w_unused = &{1'b0, pred_pc, upd_pc};

    // -------------------------------------------------------------------------
    // FSM: INIT sweeps the table, RUN serves predictions and updates.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        w_sweep_we  = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_sweep_we = !rst;
                if (!rst && (r_sweep_idx == LAST_IDX)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = !rst;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep_idx <= '0;
        end else if (w_sweep_we) begin
            r_sweep_idx <= r_sweep_idx + GHR_WIDTH'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Index generation
    // -------------------------------------------------------------------------
    always_comb begin
        w_pidx = r_ghr;
        w_uidx = upd_ghr;
        if (MODE != 0) begin
            w_pidx = r_ghr   ^ pred_pc[GHR_WIDTH+1:2];
            w_uidx = upd_ghr ^ upd_pc[GHR_WIDTH+1:2];
        end
    end

    // -------------------------------------------------------------------------
    // Prediction: reads the registered table, so a same-cycle update to the
    // same entry is seen only from the next cycle.
    // -------------------------------------------------------------------------
    assign w_ctr_msb  = r_ctr[w_pidx][CTR_WIDTH-1];
    assign pred_taken = w_run & w_ctr_msb;
    assign pred_ghr   = rst ? '0 : r_ghr;
    assign ready      = w_run;

    // -------------------------------------------------------------------------
    // Counter update (saturating)
    // -------------------------------------------------------------------------
    assign w_upd_we  = w_run & upd_valid;
    assign w_upd_cur = r_ctr[w_uidx];

    always_comb begin
        w_upd_nxt = w_upd_cur;
        if (upd_taken) begin
            if (w_upd_cur != '1) begin
                w_upd_nxt = w_upd_cur + CTR_ONE;
            end
        end else begin
            if (w_upd_cur != '0) begin
                w_upd_nxt = w_upd_cur - CTR_ONE;
            end
        end
    end

    // The table itself has no reset; the INIT sweep initialises it.
    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_ctr[r_sweep_idx] <= CTR_WNT;
        end else if (w_upd_we) begin
            r_ctr[w_uidx] <= w_upd_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Global history: repair from the snapshot wins over a speculative shift.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (w_run) begin
            if (upd_valid && upd_mispredict) begin
                r_ghr <= {upd_taken, upd_ghr[GHR_WIDTH-1:1]};
            end else if (pred_valid && !Stall_Detected) begin
                r_ghr <= {w_ctr_msb, r_ghr[GHR_WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// -----------------------------------------------------------------------------
// tb_gshare_predictor
//
// Drives two predictors (MODE=1 gshare and MODE=0 GHR-only) with identical
// stimulus. The driver computes the expected outputs for each cycle from a
// plain arithmetic reference model and pushes them into a scoreboard queue;
// a monitor on the falling clock edge pops and compares against both DUTs.
// -----------------------------------------------------------------------------
module tb_gshare_predictor;

    localparam int GW    = 3;
    localparam int DEPTH = 8;
    localparam int CW    = 2;
    localparam int CMAX  = 3;   // 2**CW - 1
    localparam int WNT   = 1;   // 2**(CW-1) - 1

    logic        clk;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        Stall_Detected;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [2:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;

    logic        taken_m1, taken_m0;
    logic [2:0]  ghr_m1, ghr_m0;
    logic        ready_m1, ready_m0;

    gshare_predictor #(
        .GHR_WIDTH(GW), .TABLE_DEPTH(DEPTH), .CTR_WIDTH(CW),
        .PC_WIDTH(32), .MODE(1)
    ) u_dut_m1 (
        .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .Stall_Detected(Stall_Detected), .pred_taken(taken_m1),
        .pred_ghr(ghr_m1), .ready(ready_m1), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict)
    );

    gshare_predictor #(
        .GHR_WIDTH(GW), .TABLE_DEPTH(DEPTH), .CTR_WIDTH(CW),
        .PC_WIDTH(32), .MODE(0)
    ) u_dut_m0 (
        .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .Stall_Detected(Stall_Detected), .pred_taken(taken_m0),
        .pred_ghr(ghr_m0), .ready(ready_m0), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  rdy;   // [0]: MODE=1 DUT, [1]: MODE=0 DUT
        logic [1:0]  tk;
        logic [2:0]  g1;    // MODE=1 DUT ghr
        logic [2:0]  g0;    // MODE=0 DUT ghr
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // ---------------- reference model ----------------
    // Model k=0 is MODE=1, k=1 is MODE=0.
    int m_tbl [2][DEPTH];
    int m_cnt [2];
    int m_ghr [2];

    function automatic int idx_of(input int k, input int g, input logic [31:0] pc);
        int pcb;
        pcb = int'((pc >> 2) % 32'd8);
        return (k == 0) ? (g ^ pcb) : g;
    endfunction

    function automatic int model_ready(input int k);
        return (!rst && m_cnt[k] >= DEPTH) ? 1 : 0;
    endfunction

    function automatic int model_taken(input int k);
        if (model_ready(k) == 0) return 0;
        return m_tbl[k][idx_of(k, m_ghr[k], pred_pc)] / 2;
    endfunction

    function automatic int model_ghr(input int k);
        return rst ? 0 : m_ghr[k];
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cnt[k] = 0;
                m_ghr[k] = 0;
                for (int i = 0; i < DEPTH; i++) m_tbl[k][i] = WNT;
            end else if (m_cnt[k] < DEPTH) begin
                m_cnt[k] = m_cnt[k] + 1;
            end else begin
                int pt;
                int u;
                pt = m_tbl[k][idx_of(k, m_ghr[k], pred_pc)] / 2;
                if (upd_valid) begin
                    u = idx_of(k, int'(upd_ghr), upd_pc);
                    if (upd_taken) m_tbl[k][u] = (m_tbl[k][u] < CMAX) ? m_tbl[k][u] + 1 : CMAX;
                    else           m_tbl[k][u] = (m_tbl[k][u] > 0) ? m_tbl[k][u] - 1 : 0;
                end
                if (upd_valid && upd_mispredict)
                    m_ghr[k] = (int'(upd_taken) * 4) + (int'(upd_ghr) / 2);
                else if (pred_valid && !Stall_Detected)
                    m_ghr[k] = (pt * 4) + (m_ghr[k] / 2);
            end
        end
    endtask

    // One cycle of stimulus: drive, queue expectation, advance model at edge.
    task automatic drive(input logic r, input logic pv, input logic [31:0] ppc,
                         input logic st, input logic uv, input logic [31:0] upc,
                         input logic [2:0] ug, input logic ut, input logic um);
        exp_t e;
        rst = r; pred_valid = pv; pred_pc = ppc; Stall_Detected = st;
        upd_valid = uv; upd_pc = upc; upd_ghr = ug; upd_taken = ut;
        upd_mispredict = um;
        e.cyc = 32'(cycle);
        e.rdy = {model_ready(1) != 0, model_ready(0) != 0};
        e.tk  = {model_taken(1) != 0, model_taken(0) != 0};
        e.g1  = 3'(model_ghr(0));
        e.g0  = 3'(model_ghr(1));
        sb.push_back(e);
        @(posedge clk);
        model_step();
        cycle++;
        #1;
    endtask

    task automatic idle(input logic [31:0] ppc);
        drive(1'b0, 1'b0, ppc, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    task automatic cmp(input logic [31:0] cyc, input string nm,
                       input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.cyc, "ready_m1", {2'b0, ready_m1}, {2'b0, e.rdy[0]});
            cmp(e.cyc, "ready_m0", {2'b0, ready_m0}, {2'b0, e.rdy[1]});
            cmp(e.cyc, "taken_m1", {2'b0, taken_m1}, {2'b0, e.tk[0]});
            cmp(e.cyc, "taken_m0", {2'b0, taken_m0}, {2'b0, e.tk[1]});
            cmp(e.cyc, "ghr_m1", ghr_m1, e.g1);
            cmp(e.cyc, "ghr_m0", ghr_m0, e.g0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; pred_valid = 1'b0; pred_pc = '0; Stall_Detected = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0;
        upd_mispredict = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_ghr[k] = 0;
            for (int i = 0; i < DEPTH; i++) m_tbl[k][i] = WNT;
        end
        @(posedge clk);
        #1;

        // Reset, partial sweep, reset again mid-sweep, then full sweep.
        repeat (3) drive(1'b1, 1'b0, $urandom, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (4) idle($urandom);
        repeat (2) drive(1'b1, 1'b0, $urandom, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (10) idle($urandom);

        // Collision: predict and taken-update on entry 4 (MODE=1), counter 01.
        drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h0, 3'd4, 1'b1, 1'b0);
        idle(32'h10);

        // Saturation on index 0: four taken, then four not-taken.
        repeat (4) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 3'd0, 1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 1'b0);
        idle(32'h0);

        // Speculative history: train index 0 to strongly-taken, predict x3,
        // then hold stall with pred_valid.
        repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 3'd0, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

        // Repair wins over same-cycle speculative shift.
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 3'b010, 1'b1, 1'b1);
        idle(32'h0);

        // MODE=0 PC independence with ghr held.
        for (int i = 0; i < 6; i++) idle($urandom);

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            logic r;
            r = ($urandom_range(0, 199) == 0);
            drive(r, 1'($urandom), $urandom, ($urandom_range(0, 3) == 0),
                  1'($urandom), $urandom, 3'($urandom), 1'($urandom),
                  ($urandom_range(0, 4) == 0));
        end
        repeat (4) idle($urandom);

        // Drain scoreboard (bounded).
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised global-history direction predictor for the fetch stage, generalising the fixed 3-bit-history, 2-bit-counter pattern-history block. Keeps a speculative global history register (GHR) updated at prediction time, a table of saturating counters indexed by GHR or by GHR XOR PC (gshare), and repairs the GHR from a pipeline-carried snapshot on mispredict. Fetch reads `pred_taken` combinationally; execute writes back outcomes. After reset, a sweep state machine clears the table.

## Interface

- `GHR_WIDTH`, 3: history length; table index width.
- `TABLE_DEPTH`, 1<<GHR_WIDTH: counter entries; must equal 2^GHR_WIDTH.
- `CTR_WIDTH`, 2: saturating counter width, at least 2.
- `PC_WIDTH`, 32: program counter width.
- `MODE`, 1: 0 = index is GHR only; 1 = index is GHR XOR `pc[GHR_WIDTH+1:2]`.

Ports:

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pred_valid`  in  1  fetch is presenting a branch for prediction.
- `pred_pc`  in  PC_WIDTH  PC of the predicted branch.
- `Stall_Detected`  in  1  pipeline stall; blocks the speculative GHR shift.
- `pred_taken`  out  1  predicted direction, combinational.
- `pred_ghr`  out  GHR_WIDTH  current speculative GHR. Fetch carries it down the pipeline as a snapshot.
- `ready`  out  1  table initialised; predictions and updates accepted.
- `upd_valid`  in  1  execute is resolving a branch.
- `upd_pc`  in  PC_WIDTH  PC of the resolved branch.
- `upd_ghr`  in  GHR_WIDTH  snapshot of `pred_ghr` taken when this branch was predicted.
- `upd_taken`  in  1  actual outcome.
- `upd_mispredict`  in  1  prediction was wrong; qualified by `upd_valid`.

## Operation

- **State.** The block holds:
  - table `ctr[TABLE_DEPTH]` of CTR_WIDTH bits;
  - `ghr`;
  - sweep counter `sweep_idx`;
  - FSM with states INIT and RUN.
- **Reset.**
  - While `rst` is high: FSM=INIT, `sweep_idx`=0, `ghr`=0.
  - Outputs under reset: `ready`=0, `pred_taken`=0, `pred_ghr`=0.
- **INIT.**
  - Each cycle writes `ctr[sweep_idx]` = weakly-not-taken, i.e. 2^(CTR_WIDTH-1)-1, then increments `sweep_idx`.
  - After the write of index TABLE_DEPTH-1, the FSM moves to RUN.
  - In INIT, `pred_valid` and `upd_valid` are ignored and `pred_taken` is forced to 0.
  - If `rst` is reasserted mid-sweep, the sweep restarts from index 0.
- **RUN, prediction.**
  - Index: `pidx` = MODE ? (`ghr` ^ `pred_pc[GHR_WIDTH+1:2]`) : `ghr`.
  - `pred_taken` = MSB of `ctr[pidx]`.
  - When `pred_valid` and not `Stall_Detected`, the next edge sets `ghr` <= {`pred_taken`, `ghr[GHR_WIDTH-1:1]`]. New history enters at the MSB and the oldest bit is dropped.
- **RUN, update.** When `upd_valid` is high (`Stall_Detected` has no effect on updates):
  - Index: `uidx` = MODE ? (`upd_ghr` ^ `upd_pc[GHR_WIDTH+1:2]`) : `upd_ghr`.
  - If `upd_taken`, `ctr[uidx]` is incremented, saturating at 2^CTR_WIDTH-1.
  - Otherwise `ctr[uidx]` is decremented, saturating at 0.
- **Repair.** When `upd_valid` and `upd_mispredict`: `ghr` <= {`upd_taken`, `upd_ghr[GHR_WIDTH-1:1]`}.
  - Repair has priority over a same-cycle speculative shift; the shift is discarded.
- **Collisions.** If a predict and an update hit the same index in the same cycle, `pred_taken` uses the pre-update value.

## Timing

- `pred_taken` and `pred_ghr` are valid in the same cycle as `pred_valid`; there is no added latency.
- The GHR shift, counter write and repair all take effect at the next rising edge and are visible to predictions from the following cycle.
- `ready` rises exactly TABLE_DEPTH cycles after the first cycle with `rst` low. With TABLE_DEPTH=8, `rst` low in cycle 0 gives `ready`=1 in cycle 8.
- The block has no handshake back-pressure: `pred_valid` and `upd_valid` are single-cycle, fire-and-forget pulses.
- Any number of predictions may be in flight between predict and update. Correctness of repair relies solely on the `upd_ghr` snapshot.

## Test plan

Configuration for all scenarios unless noted: GHR_WIDTH=3, CTR_WIDTH=2, MODE=1.

- **Init sweep.** Release `rst`, probe any `pred_pc` each cycle. Required: `ready`=0 and `pred_taken`=0 for cycles 0–7; `ready`=1 from cycle 8; every entry reads 2'b01.
- **Saturation.** Apply 4 updates with `upd_pc`=0x0, `upd_ghr`=0, `upd_taken`=1. Required: counter 01→10→11→11 and `pred_taken`=1 from the cycle after the first update. Then 4 not-taken updates: 11→10→01→00→00.
- **Speculative history.** After training index 0 to 11, apply 3 consecutive `pred_valid` cycles with `pred_pc`=0x0. Required: `ghr` 000→100→ next-index-dependent value. Holding `Stall_Detected`=1 leaves `ghr` unchanged.
- **Repair priority.** Same cycle: `pred_valid`=1, `upd_valid`=1, `upd_mispredict`=1, `upd_ghr`=3'b010, `upd_taken`=1. Required: next-cycle `ghr`=3'b101.
- **Collision.** Same cycle: predict and taken-update at the same index, counter at 01. Required: `pred_taken`=0 that cycle and 1 the next cycle.
- **Mid-sweep reset, then MODE=0.**
  - Assert `rst` at sweep cycle 4. Required: `ready` rises 8 cycles after the second release.
  - With MODE=0, a `pred_pc` change alone must not change `pred_taken`.
